// File: rtl/spi_slave_tx.sv
// SPI responder (CPOL=0). It oversamples sclk/cs/mosi in the clk domain and
// returns a preloaded word on miso, LSB first. It also captures the incoming
// mosi word. A one-entry holding buffer feeds the tx shifter at each frame start.
module spi_slave_tx #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  output logic             abort
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic [SYNC_STAGES:0]   sync_vld_q;

  logic sclk_s, cs_s, mosi_s, edges_ok;
  logic sclk_fall, cs_fall, cs_rise;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  // Pin synchronizers plus one history flop each for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      sync_vld_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      sync_vld_q  <= {sync_vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The reset fill values are not real pin levels. Edges count only after true
  // samples reach the history flop. This stops cs held low through reset from
  // looking like a fresh frame start.
  assign edges_ok  = sync_vld_q[SYNC_STAGES];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = edges_ok &  sclk_hist_q & ~sclk_s;
  assign cs_fall   = edges_ok &  cs_hist_q   & ~cs_s;
  assign cs_rise   = edges_ok & ~cs_hist_q   &  cs_s;

  // Next-state logic: buffer handshake, frame FSM, shifters and status pulses.
  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    full_d     = full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;

    if (tx_valid && !full_q) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_sh_d = '0;
          if (full_q) begin
            tx_sh_d = buf_q;
            full_d  = 1'b0;
          end else begin
            // A write landing this cycle stays buffered for the next frame.
            tx_sh_d    = '0;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          rx_sh_d = {mosi_s, rx_sh_q[WIDTH-1:1]};
          tx_sh_d = tx_sh_q >> 1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = {mosi_s, rx_sh_q[WIDTH-1:1]};
            rx_valid_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state, shifters, holding buffer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign tx_ready = ~full_q;
  assign miso     = (state_q == SHIFT) & tx_sh_q[0];
  assign miso_oe  = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx. It acts as the SPI master (CPOL=0, 11-cycle
// half-periods) and checks each outcome against hand-computed words.
module tb_spi_slave_tx;

  localparam int W = 12;
  localparam int H = 11;

  logic         clk = 1'b0;
  logic         rst, tx_valid, sclk, cs, mosi;
  logic [W-1:0] tx_data;
  logic         tx_ready, miso, miso_oe, rx_valid, underrun, abort;
  logic [W-1:0] rx_data;

  int vec = 0;
  int errs = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;

  spi_slave_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (underrun) und_cnt++;
    if (abort)    abt_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_counts();
    rxv_cnt = 0; und_cnt = 0; abt_cnt = 0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One cs-low window with nper sclk periods; mb collects miso at each falling edge.
  task automatic frame(input logic [13:0] mosi_w, input int nper, input bit wr,
                       input logic [W-1:0] wr_word, output logic [13:0] mb);
    mb = '0;
    cs = 1'b0;
    repeat (2) @(negedge clk);
    if (wr) begin tx_data = wr_word; tx_valid = 1'b1; end
    @(negedge clk);
    if (wr) tx_valid = 1'b0;
    repeat (H - 3) @(negedge clk);
    for (int i = 0; i < nper; i++) begin
      sclk = 1'b1; mosi = mosi_w[i];
      repeat (H) @(negedge clk);
      mb[i] = miso;
      sclk = 1'b0;
      repeat (H) @(negedge clk);
    end
    cs = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    vec++; if (miso !== 1'b0) begin errs++; $display("FAIL reset_miso got %b exp 0", miso); end
    vec++; if (miso_oe !== 1'b0) begin errs++; $display("FAIL reset_miso_oe got %b exp 0", miso_oe); end
    vec++; if (rx_data !== 12'h000) begin errs++; $display("FAIL reset_rx_data got %h exp 000", rx_data); end
    vec++; if ({rx_valid, underrun, abort} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b exp 000", {rx_valid, underrun, abort}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_normal();
    logic [13:0] mb;
    clear_counts();
    write_word(12'hA5C);
    vec++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL normal_ready_low got %b exp 0", tx_ready); end
    frame(14'h03F1, 12, 1'b0, '0, mb);
    vec++; if (mb[11:0] !== 12'hA5C) begin errs++; $display("FAIL normal_miso got %h exp a5c", mb[11:0]); end
    vec++; if (rx_data !== 12'h3F1) begin errs++; $display("FAIL normal_rx_data got %h exp 3f1", rx_data); end
    vec++; if (rxv_cnt !== 1) begin errs++; $display("FAIL normal_rx_valid_count got %0d exp 1", rxv_cnt); end
    vec++; if (und_cnt !== 0) begin errs++; $display("FAIL normal_underrun_count got %0d exp 0", und_cnt); end
    vec++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL normal_ready_high got %b exp 1", tx_ready); end
    vec++; if (miso_oe !== 1'b0) begin errs++; $display("FAIL normal_oe_after got %b exp 0", miso_oe); end
  endtask

  task automatic test_underrun();
    logic [13:0] mb;
    clear_counts();
    frame(14'h0800, 12, 1'b0, '0, mb);
    vec++; if (und_cnt !== 1) begin errs++; $display("FAIL underrun_count got %0d exp 1", und_cnt); end
    vec++; if (mb[11:0] !== 12'h000) begin errs++; $display("FAIL underrun_miso got %h exp 000", mb[11:0]); end
    vec++; if (rx_data !== 12'h800) begin errs++; $display("FAIL underrun_rx_data got %h exp 800", rx_data); end
    vec++; if (rxv_cnt !== 1) begin errs++; $display("FAIL underrun_rx_valid_count got %0d exp 1", rxv_cnt); end
  endtask

  task automatic test_abort();
    logic [13:0] mb;
    clear_counts();
    write_word(12'hFFF);
    frame(14'h0015, 5, 1'b0, '0, mb);
    vec++; if (mb[4:0] !== 5'h1F) begin errs++; $display("FAIL abort_miso got %h exp 1f", mb[4:0]); end
    vec++; if (abt_cnt !== 1) begin errs++; $display("FAIL abort_count got %0d exp 1", abt_cnt); end
    vec++; if (rxv_cnt !== 0) begin errs++; $display("FAIL abort_rx_valid_count got %0d exp 0", rxv_cnt); end
    vec++; if (rx_data !== 12'h800) begin errs++; $display("FAIL abort_rx_data_kept got %h exp 800", rx_data); end
    vec++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL abort_ready got %b exp 1", tx_ready); end
    vec++; if (miso_oe !== 1'b0) begin errs++; $display("FAIL abort_oe got %b exp 0", miso_oe); end
    clear_counts();
    write_word(12'h3C7);
    frame(14'h05A5, 12, 1'b0, '0, mb);
    vec++; if (mb[11:0] !== 12'h3C7) begin errs++; $display("FAIL post_abort_miso got %h exp 3c7", mb[11:0]); end
    vec++; if (rx_data !== 12'h5A5) begin errs++; $display("FAIL post_abort_rx_data got %h exp 5a5", rx_data); end
    vec++; if (rxv_cnt !== 1 || abt_cnt !== 0) begin errs++; $display("FAIL post_abort_pulses got rxv=%0d abt=%0d exp rxv=1 abt=0", rxv_cnt, abt_cnt); end
  endtask

  task automatic test_overclock();
    logic [13:0] mb;
    clear_counts();
    write_word(12'h6B2);
    frame(14'h3C3A, 14, 1'b0, '0, mb);
    vec++; if (rxv_cnt !== 1) begin errs++; $display("FAIL overclock_rx_valid_count got %0d exp 1", rxv_cnt); end
    vec++; if (rx_data !== 12'hC3A) begin errs++; $display("FAIL overclock_rx_data got %h exp c3a", rx_data); end
    vec++; if (mb[11:0] !== 12'h6B2) begin errs++; $display("FAIL overclock_miso got %h exp 6b2", mb[11:0]); end
    vec++; if (mb[13:12] !== 2'b00) begin errs++; $display("FAIL overclock_miso_extra got %b exp 00", mb[13:12]); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] mb;
    clear_counts();
    tx_data = 12'h111; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 12'h222;
    vec++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_after_first got %b exp 0", tx_ready); end
    repeat (4) @(negedge clk);
    frame(14'h0000, 12, 1'b0, '0, mb);
    tx_valid = 1'b0;
    vec++; if (mb[11:0] !== 12'h111) begin errs++; $display("FAIL b2b_first_word got %h exp 111", mb[11:0]); end
    vec++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL b2b_second_held got %b exp 0", tx_ready); end
    frame(14'h0000, 12, 1'b0, '0, mb);
    vec++; if (mb[11:0] !== 12'h222) begin errs++; $display("FAIL b2b_second_word got %h exp 222", mb[11:0]); end
    vec++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_final got %b exp 1", tx_ready); end
    clear_counts();
    frame(14'h0000, 12, 1'b1, 12'h9E4, mb);
    vec++; if (und_cnt !== 1) begin errs++; $display("FAIL fallwrite_underrun got %0d exp 1", und_cnt); end
    vec++; if (mb[11:0] !== 12'h000) begin errs++; $display("FAIL fallwrite_miso got %h exp 000", mb[11:0]); end
    vec++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL fallwrite_buffered got %b exp 0", tx_ready); end
    frame(14'h0000, 12, 1'b0, '0, mb);
    vec++; if (mb[11:0] !== 12'h9E4) begin errs++; $display("FAIL fallwrite_next_word got %h exp 9e4", mb[11:0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [13:0] mb;
    int oe_seen;
    logic [11:0] mw;
    oe_seen = 0;
    mw = 12'hABC;
    clear_counts();
    write_word(12'h0F0);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1; mosi = mw[i]; repeat (H) @(negedge clk);
      sclk = 1'b0; repeat (H) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    vec++; if ({tx_ready, miso_oe, miso} !== 3'b100) begin errs++; $display("FAIL midrst_outputs got %b exp 100", {tx_ready, miso_oe, miso}); end
    vec++; if (rx_data !== 12'h000) begin errs++; $display("FAIL midrst_rx_data got %h exp 000", rx_data); end
    rst = 1'b0;
    for (int i = 6; i < 12; i++) begin
      sclk = 1'b1; mosi = mw[i]; repeat (H) @(negedge clk);
      if (miso_oe) oe_seen++;
      sclk = 1'b0; repeat (H) @(negedge clk);
      if (miso_oe) oe_seen++;
    end
    cs = 1'b1;
    repeat (H) @(negedge clk);
    vec++; if (oe_seen !== 0) begin errs++; $display("FAIL midrst_oe_after got %0d samples high exp 0", oe_seen); end
    vec++; if (rxv_cnt !== 0 || abt_cnt !== 0) begin errs++; $display("FAIL midrst_pulses got rxv=%0d abt=%0d exp 0 0", rxv_cnt, abt_cnt); end
    clear_counts();
    write_word(12'h7E1);
    frame(14'h01B6, 12, 1'b0, '0, mb);
    vec++; if (mb[11:0] !== 12'h7E1) begin errs++; $display("FAIL midrst_clean_miso got %h exp 7e1", mb[11:0]); end
    vec++; if (rx_data !== 12'h1B6) begin errs++; $display("FAIL midrst_clean_rx got %h exp 1b6", rx_data); end
    vec++; if (rxv_cnt !== 1) begin errs++; $display("FAIL midrst_clean_rxv got %0d exp 1", rxv_cnt); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_underrun();
    test_abort();
    test_overclock();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx.md
Name: spi_slave_tx

Overview:
- Full-duplex SPI responder in the `clk` domain, sitting on the same 4-wire link as the 12-bit SPI master.
- Oversamples the external `sclk`/`cs`, shifts a preloaded word out on `miso` (LSB first), and captures the `mosi` word.
- Provides the return path the current slave lacks: the master side can read status/data back.
- Mode is CPOL=0. The master changes data after `sclk` rises; both ends sample on the `sclk` falling edge.

Parameters:
- `WIDTH`, 12, bits per frame.
- `SYNC_STAGES`, 2, synchronizer flops on `sclk`/`cs`/`mosi` (minimum 2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  `WIDTH`  word to return on the next frame.
- `tx_valid`  in  1  `tx_data` valid. Accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  one-entry holding buffer empty.
- `sclk`  in  1  SPI clock from master (asynchronous to `clk`).
- `cs`  in  1  chip select, active-low.
- `mosi`  in  1  master-out data.
- `miso`  out  1  slave-out data.
- `miso_oe`  out  1  output enable for the pad tristate; 1 while selected.
- `rx_data`  out  `WIDTH`  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `underrun`  out  1  one-cycle pulse: frame started with an empty buffer.
- `abort`  out  1  one-cycle pulse: `cs` rose before `WIDTH` bits were received.

Behaviour:
- **Reset values.**
  - `tx_ready`=1; `miso`=0; `miso_oe`=0; `rx_data`=0; `rx_valid`=0; `underrun`=0; `abort`=0; buffer empty; bit count 0; state IDLE.
  - Synchronizer flops reset to idle pin levels: `cs`=1, `sclk`=0.
- **Synchronization.**
  - `sclk`, `cs` and `mosi` each pass through `SYNC_STAGES` flops, plus one history flop for edge detection.
  - A pin change is acted on `SYNC_STAGES`+1 `clk` cycles later (3 by default).
  - Legal operation requires each `sclk` half-period ≥ `SYNC_STAGES`+2 `clk` cycles.
- **Holding buffer.**
  - A write is accepted on the cycle `tx_valid && tx_ready`.
  - `tx_ready` falls the next cycle and rises again the cycle after the buffer is consumed.
  - `tx_ready` is a registered state. A write in the same cycle as consumption, while full, is not accepted.
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE.**
  - `miso`=0, `miso_oe`=0. `sclk` edges are ignored.
  - On a detected `cs` falling edge: go to SHIFT, `miso_oe`=1, count=0.
  - If the buffer is full: load it into the tx shifter and mark it empty.
  - Otherwise: load all zeros and pulse `underrun`.
  - A write accepted in the same cycle as the `cs` fall does not feed the current frame; it stays in the buffer for the next frame, and `underrun` still pulses.
- **SHIFT.**
  - `miso` always equals tx shifter bit 0, so bit 0 is on `miso` before the first `sclk` edge.
  - Each detected `sclk` falling edge, in one cycle:
    - shift synced `mosi` into the rx shifter MSB side (`{mosi, rx[WIDTH-1:1]}`), so the first bit ends at bit 0;
    - shift the tx shifter right, filling 0;
    - count+1.
  - `sclk` rising edges cause no action.
  - When count reaches `WIDTH`: `rx_data` ← rx shifter, pulse `rx_valid` (the cycle after the `WIDTH`-th fall), go to DONE.
- **DONE.**
  - `miso`=0, `miso_oe` stays 1. Extra `sclk` edges are ignored: no count change, no second `rx_valid`.
  - `cs` rising edge → IDLE, `miso_oe`=0.
- **`cs` rising edge in SHIFT (count < `WIDTH`):** pulse `abort`, go to IDLE. `rx_data` is unchanged and no `rx_valid` is issued. The consumed tx word is lost, not restored.
- **`cs` rising and a `sclk` falling edge detected in the same cycle:** `cs` wins. The bit is discarded.
- **Reset mid-frame:** all state is cleared. Because `cs` sync resets to 1, a frame still in progress with `cs` held low is ignored. The next frame begins only at a fresh `cs` falling edge.
- **Count width:** `$clog2(WIDTH+1)` bits; there is no wrap inside a frame.

Test Plan:
- **Normal frame:** load `tx_data`=12'hA5C, `cs` low, 12 `sclk` periods (11-cycle half-periods) with the master sending 12'h3F1 LSB first → `miso` bits sampled at falling edges are LSB-first 12'hA5C; `rx_data`=12'h3F1; exactly one `rx_valid`; `tx_ready` returns to 1.
- **Underrun:** no `tx_valid`, run a frame with `mosi` word 12'h800 → `underrun` pulses once at the `cs` fall; `miso` is 0 for all bits; `rx_data`=12'h800.
- **Abort:** load 12'hFFF, drop `cs`, 5 `sclk` falls, raise `cs` → `abort` pulse; no `rx_valid`; `rx_data` keeps its prior value; `tx_ready`=1; the next full frame works normally.
- **Over-clocked frame:** 14 `sclk` periods in one `cs` window → `rx_valid` after the 12th fall only; `miso`=0 during periods 13–14.
- **Buffer handshake:** hold `tx_valid` with 12'h111 then 12'h222 back-to-back → only 12'h111 accepted (`tx_ready` 0 afterwards); after the frame consumes it, 12'h222 is accepted and appears in the next frame. Also write in the exact cycle of the detected `cs` fall → `underrun`=1 and the word appears in the following frame.
- **Reset mid-frame:** assert `rst` after 6 bits with `cs` still low, release, finish the clocks, then run a clean frame → no `rx_valid` for the partial frame; outputs at reset values; the clean frame is received correctly.
